// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the hazard controller slice.
//   hz_state_t : controller states (IDLE, STALL, FLUSH, TRACK)
//   HZ_CNT_W   : width of the shared STALL/FLUSH down-counter
//   fwd_w(d)   : width of a forwarding select for d producer slots
//                (0 = register file, k+1 = slot k)
// Optional feature macro used by this slice: HAZARD_FWD_EN
// -----------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    HZ_IDLE  = 2'd0,
    HZ_STALL = 2'd1,
    HZ_FLUSH = 2'd2,
    HZ_TRACK = 2'd3
  } hz_state_t;

  localparam int HZ_CNT_W = 3;

  function automatic int fwd_w(input int d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Decode/producer bundle between the pipeline (master) and the hazard
// controller (slave).
//   rs1_d, rs2_d   : decode source registers
//   rs_used        : bit0 -> rs1_d read, bit1 -> rs2_d read
//   rd_slot        : destination of producer slot k at [k*REG_AW +: REG_AW]
//   wr_slot        : slot k writes a register
//   ld_slot        : slot k is a load
//   branch_taken_e : branch resolved taken in execute
//   stall_f, flush, track : registered controls back to fetch/decode
//   fwd_a, fwd_b   : forwarding selects (only with HAZARD_FWD_EN)
// -----------------------------------------------------------------------------
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int NUM_STAGES = 2
);

  localparam int D  = NUM_STAGES - 1;
  localparam int FW = fwd_w(D);

  logic [REG_AW-1:0]   rs1_d;
  logic [REG_AW-1:0]   rs2_d;
  logic [1:0]          rs_used;
  logic [D*REG_AW-1:0] rd_slot;
  logic [D-1:0]        wr_slot;
  logic [D-1:0]        ld_slot;
  logic                branch_taken_e;
  logic                stall_f;
  logic                flush;
  logic                track;
`ifdef HAZARD_FWD_EN
  logic [FW-1:0]       fwd_a;
  logic [FW-1:0]       fwd_b;
`endif

  modport master (
    output rs1_d, rs2_d, rs_used, rd_slot, wr_slot, ld_slot, branch_taken_e,
    input  stall_f, flush, track
`ifdef HAZARD_FWD_EN
    , input fwd_a, fwd_b
`endif
  );

  modport slave (
    input  rs1_d, rs2_d, rs_used, rd_slot, wr_slot, ld_slot, branch_taken_e,
    output stall_f, flush, track
`ifdef HAZARD_FWD_EN
    , output fwd_a, fwd_b
`endif
  );

endinterface

// File: rtl/hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Combinational RAW match of one decode source against D producer slots.
//   rs      : source register address
//   used    : source is actually read
//   rd_slot : packed destinations, slot k at [k*REG_AW +: REG_AW]
//   wr_slot : slot k writes a register
//   hit     : some slot matches
//   idx     : nearest (lowest) matching slot; 0 when no hit
// Register 0 never matches.
// -----------------------------------------------------------------------------
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int D      = 1
) (
  input  logic [REG_AW-1:0]   rs,
  input  logic                used,
  input  logic [D*REG_AW-1:0] rd_slot,
  input  logic [D-1:0]        wr_slot,
  output logic                hit,
  output logic [fwd_w(D)-1:0] idx
);

  localparam int IW = fwd_w(D);

  logic [D-1:0]  match_s;
  logic          hit_s;
  logic [IW-1:0] idx_s;

  // Per-slot match flags
  always_comb begin
    match_s = {D{1'b0}};
    for (int k = 0; k < D; k++) begin
      match_s[k] = wr_slot[k] && used
                 && (rd_slot[k*REG_AW +: REG_AW] != {REG_AW{1'b0}})
                 && (rd_slot[k*REG_AW +: REG_AW] == rs);
    end
  end

  // Priority pick: scan far-to-near so the nearest slot overwrites last
  always_comb begin
    hit_s = 1'b0;
    idx_s = {IW{1'b0}};
    for (int k = D - 1; k >= 0; k--) begin
      hit_s = hit_s | match_s[k];
      idx_s = match_s[k] ? IW'(k) : idx_s;
    end
  end

  assign hit = hit_s;
  assign idx = idx_s;

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// RAW hazard controller for 2/3/4-stage pipelines. Detects decode-source
// hazards against NUM_STAGES-1 in-flight producers, issues multi-cycle fetch
// stalls, multi-cycle branch flushes and a one-cycle track pulse after each
// flush.
// Parameters: REG_AW (address width), NUM_STAGES (2..4), FLUSH_CYCLES (1..4).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : hazard_ctrl_if.slave (sources, producer slots, branch in;
//           stall_f / flush / track out, fwd_a / fwd_b with HAZARD_FWD_EN)
// Optional feature macro: HAZARD_FWD_EN. When defined, only load-use in
// slot 0 stalls (always 1 cycle) and combinational forwarding selects are
// produced; otherwise any match stalls for D-k_min cycles.
// -----------------------------------------------------------------------------
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW       = 4,
  parameter int NUM_STAGES   = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  hazard_ctrl_if.slave bus
);

  localparam int D  = NUM_STAGES - 1;
  localparam int FW = fwd_w(D);

  localparam logic [1:0] S_IDLE  = HZ_IDLE;
  localparam logic [1:0] S_STALL = HZ_STALL;
  localparam logic [1:0] S_FLUSH = HZ_FLUSH;
  localparam logic [1:0] S_TRACK = HZ_TRACK;

  localparam logic [HZ_CNT_W-1:0] CNT_ZERO = {HZ_CNT_W{1'b0}};
  localparam logic [HZ_CNT_W-1:0] CNT_ONE  = HZ_CNT_W'(1);
  localparam logic [HZ_CNT_W-1:0] FLUSH_LD = HZ_CNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]          state_r;
  logic [1:0]          state_s;
  logic [HZ_CNT_W-1:0] cnt_r;
  logic [HZ_CNT_W-1:0] cnt_s;
  logic                stall_f_r;
  logic                flush_r;
  logic                track_r;

  logic                hit_a_s;
  logic                hit_b_s;
  logic [FW-1:0]       idx_a_s;
  logic [FW-1:0]       idx_b_s;
  logic                stall_req_s;
  logic [HZ_CNT_W-1:0] stall_ld_s;

  hazard_match #(.REG_AW(REG_AW), .D(D)) u_match_a (
    .rs      (bus.rs1_d),
    .used    (bus.rs_used[0]),
    .rd_slot (bus.rd_slot),
    .wr_slot (bus.wr_slot),
    .hit     (hit_a_s),
    .idx     (idx_a_s)
  );

  hazard_match #(.REG_AW(REG_AW), .D(D)) u_match_b (
    .rs      (bus.rs2_d),
    .used    (bus.rs_used[1]),
    .rd_slot (bus.rd_slot),
    .wr_slot (bus.wr_slot),
    .hit     (hit_b_s),
    .idx     (idx_b_s)
  );

`ifdef HAZARD_FWD_EN
  // Load-use in the nearest slot is the only hazard forwarding cannot cover
  always_comb begin
    stall_req_s = bus.ld_slot[0]
                && ((hit_a_s && (idx_a_s == {FW{1'b0}}))
                 || (hit_b_s && (idx_b_s == {FW{1'b0}})));
    stall_ld_s  = CNT_ZERO;
  end

  assign bus.fwd_a = hit_a_s ? (idx_a_s + FW'(1)) : {FW{1'b0}};
  assign bus.fwd_b = hit_b_s ? (idx_b_s + FW'(1)) : {FW{1'b0}};
`else
  logic [FW-1:0] kmin_s;
  logic          unused_ld_s;

  // Nearest matching slot across both sources sets the stall length
  always_comb begin
    if (hit_a_s && hit_b_s) begin
      kmin_s = (idx_a_s < idx_b_s) ? idx_a_s : idx_b_s;
    end else if (hit_a_s) begin
      kmin_s = idx_a_s;
    end else begin
      kmin_s = idx_b_s;
    end
  end

  // Counter holds remaining stall cycles minus one: D-k_min-1
  always_comb begin
    stall_req_s = hit_a_s | hit_b_s;
    stall_ld_s  = HZ_CNT_W'(D - 1) - HZ_CNT_W'(kmin_s);
  end

  assign unused_ld_s = ^bus.ld_slot;
`endif

  // Next-state and shared counter; branch outranks hazard
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (bus.branch_taken_e) begin
          state_s = S_FLUSH;
          cnt_s   = FLUSH_LD;
        end else if (stall_req_s) begin
          state_s = S_STALL;
          cnt_s   = stall_ld_s;
        end else begin
          state_s = S_IDLE;
          cnt_s   = cnt_r;
        end
      end
      S_STALL: begin
        // New matches while stalled belong to the hazard already draining
        if (bus.branch_taken_e) begin
          state_s = S_FLUSH;
          cnt_s   = FLUSH_LD;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = S_IDLE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = S_STALL;
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_FLUSH: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_TRACK;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = S_FLUSH;
          cnt_s   = cnt_r - CNT_ONE;
        end
      end
      S_TRACK: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered decode of the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= CNT_ZERO;
      stall_f_r <= 1'b0;
      flush_r   <= 1'b0;
      track_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      stall_f_r <= (state_s == S_STALL);
      flush_r   <= (state_s == S_FLUSH);
      track_r   <= (state_s == S_TRACK);
    end
  end

  assign bus.stall_f = stall_f_r;
  assign bus.flush   = flush_r;
  assign bus.track   = track_r;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 2/3/4-stage pipelines: detects read-after-write hazards between the decode-side source registers and up to `NUM_STAGES-1` in-flight producers. It issues multi-cycle fetch stalls and multi-cycle branch flushes through an explicit state machine, and raises a one-cycle `track` recovery pulse after each flush. It sits beside the fetch/decode register and drives its hold and bubble controls. It replaces the fixed 4-bit, single-producer, one-cycle-stall hazard unit.

## Interface
Parameters:
- `REG_AW`, default 4: register-address width.
- `NUM_STAGES`, default 2, legal 2..4: pipeline depth. `D = NUM_STAGES-1` producer slots.
- `FLUSH_CYCLES`, default 1, legal 1..4: number of bubble cycles after a taken branch.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `reset`, in, 1: reset, asynchronous, active-high.
- `rs1_d`, in, `REG_AW`: source register 1 of the instruction in decode.
- `rs2_d`, in, `REG_AW`: source register 2 of the instruction in decode.
- `rs_used`, in, 2: bit0 means `rs1_d` is read; bit1 means `rs2_d` is read.
- `rd_slot`, in, `D*REG_AW`: destination register of producer slot k, at bits `[k*REG_AW +: REG_AW]`. Slot 0 is execute (nearest).
- `wr_slot`, in, `D`: slot k writes a register.
- `ld_slot`, in, `D`: slot k is a load.
- `branch_taken_e`, in, 1: branch resolved taken in execute.
- `stall_f`, out, 1: hold fetch/decode; registered.
- `flush`, out, 1: insert bubble into decode; registered.
- `track`, out, 1: one-cycle recovery pulse after a flush; registered.
- `fwd_a`, out, `$clog2(D+1)`: forwarding select for rs1; present only with `HAZARD_FWD_EN`.
- `fwd_b`, out, `$clog2(D+1)`: forwarding select for rs2; present only with `HAZARD_FWD_EN`.

## Operation
- **Match:** slot k matches a source when `wr_slot[k]`, the source's `rs_used` bit is set, `rd_slot[k] != 0`, and the addresses are equal. Register 0 never causes a hazard. The nearest match is the lowest k.
- **States:** IDLE, STALL, FLUSH, TRACK. A 3-bit down-counter `cnt` is shared between STALL and FLUSH.
- **IDLE:**
  - `branch_taken_e` → FLUSH, `cnt=FLUSH_CYCLES-1`.
  - Otherwise, a stall condition → STALL, `cnt=D-k_min-1`, where k_min is the nearest matching slot.
  - Otherwise stay in IDLE.
- **STALL:** `stall_f=1`.
  - `branch_taken_e` aborts the stall → FLUSH, with the counter loaded as above.
  - Else when `cnt==0` → IDLE; otherwise decrement.
  - New matches are ignored; they are the same hazard draining.
- **FLUSH:** `flush=1`, `stall_f=0`, `branch_taken_e` ignored. When `cnt==0` → TRACK; otherwise decrement.
- **TRACK:** `track=1` for exactly one cycle → IDLE. Branch and hazard inputs are ignored in this cycle.
- **Priority:** branch > hazard.
- **Output encoding:** outputs are a registered decode of the next state.
  - `stall_f` is 1 only when next state is STALL.
  - `flush` is 1 only when next state is FLUSH.
  - `track` is 1 only when next state is TRACK.
  - The three outputs are mutually exclusive.

## Timing
- Reset (async): state IDLE, `cnt=0`, `stall_f=0`, `flush=0`, `track=0`. Reset mid-STALL or mid-FLUSH aborts immediately with no trailing `track`.
- Inputs are sampled at edge t. The resulting output is visible after edge t.
- Stall length without forwarding is `D-k_min` cycles: NUM_STAGES=2 gives 1 cycle; a slot-0 match at NUM_STAGES=4 gives 3 cycles.
- A taken branch gives `FLUSH_CYCLES` cycles of `flush`, then 1 cycle of `track`. Total non-IDLE time is `FLUSH_CYCLES+1` cycles.
- A branch and a hazard sampled on the same edge produce FLUSH only.
- A branch on the last STALL cycle still goes to FLUSH.

## Configuration
- **`HAZARD_FWD_EN` undefined:** any match stalls as above. `fwd_a` and `fwd_b` do not exist.
- **`HAZARD_FWD_EN` defined:**
  - The stall condition is restricted to a match in slot 0 with `ld_slot[0]=1` (load-use). The stall is always 1 cycle.
  - `fwd_a`/`fwd_b` are combinational: 0 selects the register file, k+1 selects the nearest matching slot k.
  - Forwarding selects are valid in every state. The consumer ignores them while stalled.

## Structure
- **Package `hazard_pkg`:** state enum `hz_state_t` (IDLE, STALL, FLUSH, TRACK), constant `HZ_CNT_W=3`, and function `fwd_w(D)` returning `$clog2(D+1)`.
- **Sub-module `hazard_match`:** combinational, parameterised on `REG_AW` and `D`. For one source it outputs a `hit` flag and the nearest-slot index. It is instantiated once per source.

## Test plan
Test configuration: NUM_STAGES=4, REG_AW=4, FLUSH_CYCLES=2.
- **Slot-0 match:** `rs1_d=5`, `rs_used=01`, `rd_slot[0]=5`, `wr_slot=001`, no forwarding → `stall_f=1` for 3 cycles, then 0.
- **Register 0:** `rd_slot[0]=0`, `rs1_d=0`, `wr_slot=001` → `stall_f` stays 0.
- **Branch, then branch during flush:** `branch_taken_e` pulse → `flush=1` for 2 cycles, then `track=1` for 1 cycle, then all 0. A second branch raised during FLUSH is ignored.
- **Branch aborts stall:** hazard stall starts; on its 2nd cycle `branch_taken_e=1` → next cycle `stall_f=0`, `flush=1`, followed by the normal 2+1 sequence.
- **`HAZARD_FWD_EN` forwarding and load-use:**
  - `rs2_d=7`, `rs_used=10`, `rd_slot[1]=7` (non-load) → no stall, `fwd_b=2`.
  - Same source with `rd_slot[0]=7` and `ld_slot[0]=1` → `stall_f=1` for exactly 1 cycle.
- **Reset mid-flush:** assert `reset` mid-FLUSH → all outputs 0 immediately; after release, `track` never pulses.
